// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: read-only fetch port and load/store data port
// share one registered bus with data-priority arbitration and a fetch starvation guard.
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iIReq,
  input  logic [31:0] iIAddr,
  output logic        oIGnt,
  output logic        oIValid,
  output logic [31:0] oIData,
  input  logic        iDReq,
  input  logic        iDWe,
  input  logic [3:0]  iDByteEn,
  input  logic [31:0] iDAddr,
  input  logic [31:0] iDWData,
  output logic        oDGnt,
  output logic        oDValid,
  output logic [31:0] oDData,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData,
  output logic        oBusy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    ISSUE_WR,
    WAIT,
    RESP
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [2:0]  latCnt;
  logic [3:0]  starveCnt;
  logic        ownerFetch;
  logic        arbPoint;
  logic        anyReq;
  logic        winFetch;

  assign oBusy = (state != IDLE);

  always_comb begin
    arbPoint  = (state == IDLE) || (state == RESP);
    anyReq    = iIReq || iDReq;
    // Data wins ties unless fetch has lost STARVE_LIMIT times in a row.
    winFetch  = iIReq && (!iDReq || (starveCnt == 4'(STARVE_LIMIT)));
    nextState = state;
    case (state)
      IDLE, RESP: begin
        if (anyReq) begin
          if (winFetch || !iDWe) nextState = ISSUE_RD;
          else                   nextState = ISSUE_WR;
        end else begin
          nextState = IDLE;
        end
      end
      ISSUE_WR: nextState = IDLE;
      ISSUE_RD: nextState = WAIT;
      WAIT:     nextState = (latCnt == 3'd1) ? RESP : WAIT;
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= nextState;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oIGnt        <= 1'b0;
      oIValid      <= 1'b0;
      oIData       <= '0;
      oDGnt        <= 1'b0;
      oDValid      <= 1'b0;
      oDData       <= '0;
      oReadEnable  <= 1'b0;
      oWriteEnable <= 1'b0;
      oByteEnable  <= '0;
      oAddress     <= '0;
      oWriteData   <= '0;
      latCnt       <= '0;
      starveCnt    <= '0;
      ownerFetch   <= 1'b0;
    end else begin
      oIGnt        <= 1'b0;
      oDGnt        <= 1'b0;
      oIValid      <= 1'b0;
      oDValid      <= 1'b0;
      oWriteEnable <= 1'b0;

      if (arbPoint) begin
        if (!iIReq || winFetch)
          starveCnt <= '0;
        else if (starveCnt != 4'(STARVE_LIMIT))
          starveCnt <= starveCnt + 4'd1;
      end

      case (nextState)
        ISSUE_RD: begin
          oReadEnable <= 1'b1;
          oAddress    <= winFetch ? iIAddr : iDAddr;
          oByteEnable <= winFetch ? 4'hF : iDByteEn;
          oIGnt       <= winFetch;
          oDGnt       <= !winFetch;
          ownerFetch  <= winFetch;
          latCnt      <= 3'(READ_LATENCY);
        end
        ISSUE_WR: begin
          oReadEnable  <= 1'b0;
          oWriteEnable <= 1'b1;
          oAddress     <= iDAddr;
          oByteEnable  <= iDByteEn;
          oWriteData   <= iDWData;
          oDGnt        <= 1'b1;
        end
        WAIT: begin
          if (state == WAIT) latCnt <= latCnt - 3'd1;
        end
        RESP: begin
          oReadEnable <= 1'b0;
          oByteEnable <= '0;
          oIValid     <= ownerFetch;
          oDValid     <= !ownerFetch;
        end
        default: begin
          oReadEnable <= 1'b0;
          oByteEnable <= '0;
        end
      endcase

      // Last wait cycle: the bus word is valid now, latch it for the owner.
      if ((state == WAIT) && (latCnt == 3'd1)) begin
        if (ownerFetch) oIData <= iReadData;
        else            oDData <= iReadData;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a scoreboard of expected grants and read data.
module tb_mem_bus_arbiter;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Instance 1: default latency
  logic        iRST_n;
  logic        iIReq;
  logic [31:0] iIAddr;
  logic        oIGnt, oIValid;
  logic [31:0] oIData;
  logic        iDReq, iDWe;
  logic [3:0]  iDByteEn;
  logic [31:0] iDAddr, iDWData;
  logic        oDGnt, oDValid;
  logic [31:0] oDData;
  logic        oReadEnable, oWriteEnable;
  logic [3:0]  oByteEnable;
  logic [31:0] oAddress, oWriteData;
  logic [31:0] iReadData;
  logic        oBusy;

  // Instance 2: READ_LATENCY=3, fetch port only
  logic        rst2_n;
  logic        iIReq2;
  logic [31:0] iIAddr2;
  logic        oIGnt2, oIValid2;
  logic [31:0] oIData2;
  logic        dReq2, dWe2;
  logic [3:0]  dBe2;
  logic [31:0] dAddr2, dWData2;
  logic        oDGnt2, oDValid2;
  logic [31:0] oDData2;
  logic        oRe2, oWe2;
  logic [3:0]  oBe2;
  logic [31:0] oAddr2, oWData2;
  logic [31:0] iReadData2;
  logic        oBusy2;

  function automatic logic [31:0] memRd(input logic [31:0] a);
    if (a == 32'h0040_0004) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h3C3C_1234;
  endfunction

  always_comb iReadData  = memRd(oAddress);
  always_comb iReadData2 = 32'hA500_0000 ^ 32'(cyc);

  mem_bus_arbiter dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iIReq(iIReq), .iIAddr(iIAddr), .oIGnt(oIGnt), .oIValid(oIValid), .oIData(oIData),
    .iDReq(iDReq), .iDWe(iDWe), .iDByteEn(iDByteEn), .iDAddr(iDAddr), .iDWData(iDWData),
    .oDGnt(oDGnt), .oDValid(oDValid), .oDData(oDData),
    .oReadEnable(oReadEnable), .oWriteEnable(oWriteEnable), .oByteEnable(oByteEnable),
    .oAddress(oAddress), .oWriteData(oWriteData), .iReadData(iReadData), .oBusy(oBusy)
  );

  mem_bus_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .iCLK(iCLK), .iRST_n(rst2_n),
    .iIReq(iIReq2), .iIAddr(iIAddr2), .oIGnt(oIGnt2), .oIValid(oIValid2), .oIData(oIData2),
    .iDReq(dReq2), .iDWe(dWe2), .iDByteEn(dBe2), .iDAddr(dAddr2), .iDWData(dWData2),
    .oDGnt(oDGnt2), .oDValid(oDValid2), .oDData(oDData2),
    .oReadEnable(oRe2), .oWriteEnable(oWe2), .oByteEnable(oBe2),
    .oAddress(oAddr2), .oWriteData(oWData2), .iReadData(iReadData2), .oBusy(oBusy2)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] iExpQ[$];
  logic [31:0] dExpQ[$];
  logic [7:0]  grantQ[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic allZero(input string tag);
    chk({tag, "_ctl"}, {24'b0, oIGnt, oIValid, oDGnt, oDValid, oReadEnable, oWriteEnable,
                        oBusy, |oByteEnable}, 32'h0);
    chk({tag, "_addr"}, oAddress, 32'h0);
    chk({tag, "_wdata"}, oWriteData, 32'h0);
    chk({tag, "_idata"}, oIData, 32'h0);
    chk({tag, "_ddata"}, oDData, 32'h0);
  endtask

  task automatic waitGrant(input logic fetch, input string tag);
    for (int k = 0; k < 30; k++) begin
      @(negedge iCLK);
      if (fetch ? oIGnt : oDGnt) return;
    end
    chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  // Scoreboard: grants and read responses are matched in order.
  always @(negedge iCLK) begin
    if (oIGnt || oDGnt) begin
      if (grantQ.size() == 0) chk("grantUnexpected", {31'b0, oIGnt}, 32'hFFFF_FFFF);
      else chk("grantPort", {24'b0, (oIGnt ? 8'h49 : 8'h44)}, {24'b0, grantQ.pop_front()});
      chk("grantOneHot", {31'b0, oIGnt & oDGnt}, 32'h0);
    end
    if (oIValid) begin
      if (iExpQ.size() == 0) chk("iValidUnexpected", oIData, 32'hFFFF_FFFF);
      else chk("iData", oIData, iExpQ.pop_front());
    end
    if (oDValid) begin
      if (dExpQ.size() == 0) chk("dValidUnexpected", oDData, 32'hFFFF_FFFF);
      else chk("dData", oDData, dExpQ.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nG;
    int gc;
    int lastGnt;
    int lat;
    logic haveData;
    logic busyWatch;
    logic done;
    logic [31:0] holdData;
    logic [31:0] addr;

    iRST_n = 1'b0; rst2_n = 1'b0;
    iIReq = 0; iIAddr = 0; iDReq = 0; iDWe = 0; iDByteEn = 0; iDAddr = 0; iDWData = 0;
    iIReq2 = 0; iIAddr2 = 0; dReq2 = 0; dWe2 = 0; dBe2 = 0; dAddr2 = 0; dWData2 = 0;
    repeat (2) @(negedge iCLK);
    allZero("reset");
    @(posedge iCLK); #1;
    iRST_n = 1'b1; rst2_n = 1'b1;

    // Single fetch
    @(posedge iCLK); #1;
    iIReq = 1; iIAddr = 32'h0040_0004;
    iExpQ.push_back(32'h0000_0013); grantQ.push_back(8'h49);
    @(negedge iCLK);
    chk("t1_c0_busy", {31'b0, oBusy}, 32'h0);
    @(negedge iCLK);
    chk("t1_c1_gnt", {31'b0, oIGnt}, 32'h1);
    chk("t1_c1_re", {31'b0, oReadEnable}, 32'h1);
    chk("t1_c1_be", {28'b0, oByteEnable}, 32'hF);
    chk("t1_c1_addr", oAddress, 32'h0040_0004);
    @(posedge iCLK); #1 iIReq = 0;
    @(negedge iCLK);
    chk("t1_c2_re", {31'b0, oReadEnable}, 32'h1);
    chk("t1_c2_gnt", {31'b0, oIGnt}, 32'h0);
    @(negedge iCLK);
    chk("t1_c3_valid", {31'b0, oIValid}, 32'h1);
    chk("t1_c3_idata", oIData, 32'h0000_0013);
    chk("t1_c3_re", {31'b0, oReadEnable}, 32'h0);

    // Single store
    @(posedge iCLK); #1;
    iDReq = 1; iDWe = 1; iDAddr = 32'h1001_0000; iDWData = 32'hDEAD_BEEF; iDByteEn = 4'b0011;
    grantQ.push_back(8'h44);
    @(negedge iCLK);
    @(negedge iCLK);
    chk("t2_we", {31'b0, oWriteEnable}, 32'h1);
    chk("t2_re", {31'b0, oReadEnable}, 32'h0);
    chk("t2_addr", oAddress, 32'h1001_0000);
    chk("t2_wdata", oWriteData, 32'hDEAD_BEEF);
    chk("t2_be", {28'b0, oByteEnable}, 32'h3);
    chk("t2_gnt", {31'b0, oDGnt}, 32'h1);
    @(posedge iCLK); #1 iDReq = 0; iDWe = 0;
    @(negedge iCLK);
    chk("t2_we_off", {31'b0, oWriteEnable}, 32'h0);
    chk("t2_busy_off", {31'b0, oBusy}, 32'h0);
    repeat (2) @(negedge iCLK);

    // Both ports held continuously: starvation guard pattern
    @(posedge iCLK); #1;
    iIReq = 1; iIAddr = 32'h0000_0100;
    iDReq = 1; iDWe = 0; iDByteEn = 4'hF; iDAddr = 32'h0000_2000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        grantQ.push_back(8'h44); dExpQ.push_back(memRd(32'h0000_2000));
      end
      grantQ.push_back(8'h49); iExpQ.push_back(memRd(32'h0000_0100));
    end
    nG = 0;
    for (int k = 0; k < 200 && nG < 10; k++) begin
      @(negedge iCLK);
      if (oIGnt || oDGnt) nG++;
    end
    chk("t3_grants", 32'(nG), 32'd10);
    @(posedge iCLK); #1 iIReq = 0; iDReq = 0;
    repeat (4) @(negedge iCLK);
    chk("t3_pending", 32'(iExpQ.size() + dExpQ.size() + grantQ.size()), 32'h0);

    // Reset during the wait phase of a load
    @(posedge iCLK); #1;
    iDReq = 1; iDWe = 0; iDAddr = 32'h0000_3000; iDByteEn = 4'hF;
    grantQ.push_back(8'h44);
    waitGrant(1'b0, "t4_gnt");
    @(posedge iCLK); #1 iDReq = 0;
    chk("t4_in_wait", {31'b0, oReadEnable}, 32'h1);
    iRST_n = 1'b0;
    #1 allZero("t4_rst");
    @(posedge iCLK); #1 iRST_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLK);
      chk("t4_no_valid", {31'b0, oDValid}, 32'h0);
    end
    @(posedge iCLK); #1;
    iDReq = 1; iDAddr = 32'h0000_3004;
    grantQ.push_back(8'h44); dExpQ.push_back(memRd(32'h0000_3004));
    waitGrant(1'b0, "t4_regnt");
    @(posedge iCLK); #1 iDReq = 0;
    repeat (3) @(negedge iCLK);
    chk("t4_served", 32'(dExpQ.size()), 32'h0);

    // Latency-3 instance: Valid timing and which bus cycle is captured
    for (int r = 0; r < 2; r++) begin
      @(posedge iCLK); #1;
      iIReq2 = 1; iIAddr2 = 32'h0000_8000 + 32'(r * 64);
      gc = -1;
      for (int k = 0; k < 30 && gc < 0; k++) begin
        @(negedge iCLK);
        if (oIGnt2) gc = cyc;
      end
      chk("t5_gnt", {31'b0, oIGnt2}, 32'h1);
      chk("t5_addr", oAddr2, 32'h0000_8000 + 32'(r * 64));
      @(posedge iCLK); #1 iIReq2 = 0;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
        @(negedge iCLK);
        if (cyc == gc + 3) chk("t5_re_held", {31'b0, oRe2}, 32'h1);
        if (oIValid2) lat = cyc - gc;
      end
      chk("t5_latency", 32'(lat), 32'd4);
      chk("t5_data", oIData2, 32'hA500_0000 ^ 32'(gc + 3));
    end

    // Back-to-back loads with the data request held
    @(posedge iCLK); #1;
    addr = 32'h0000_4000;
    iDReq = 1; iDWe = 0; iDByteEn = 4'hF; iDAddr = addr;
    grantQ.push_back(8'h44); dExpQ.push_back(memRd(addr));
    nG = 0; lastGnt = 0; haveData = 0; busyWatch = 0; done = 0; holdData = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge iCLK);
      if (busyWatch) chk("t6_busy", {31'b0, oBusy}, 32'h1);
      if (oDValid) holdData = oDData;
      else if (haveData) chk("t6_hold", oDData, holdData);
      haveData = haveData | oDValid;
      if (oDValid && nG == 4) done = 1;
      if (oDGnt) begin
        if (nG > 0) chk("t6_spacing", 32'(cyc - lastGnt), 32'd3);
        lastGnt = cyc; nG++; busyWatch = 1;
        @(posedge iCLK); #1;
        if (nG < 4) begin
          addr = addr + 32'h40; iDAddr = addr;
          grantQ.push_back(8'h44); dExpQ.push_back(memRd(addr));
        end else begin
          iDReq = 0;
        end
      end
    end
    chk("t6_done", {31'b0, done}, 32'h1);
    @(negedge iCLK);
    chk("t6_idle_busy", {31'b0, oBusy}, 32'h0);
    chk("t6_final_hold", oDData, holdData);
    chk("t6_pending", 32'(iExpQ.size() + dExpQ.size() + grantQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
